// File: rtl/adder_arb.sv
// Round-robin arbiter sharing one 3-cycle pipelined W+1-bit adder among N requesters.
// Optional macro ADDER_ARB_CNT_EN enables the saturating completed-operation counter on CNT.
module adder_arb #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           EN,
  input  logic [N-1:0]   REQ,
  input  logic [N*W-1:0] IN1_BUS,
  input  logic [N*W-1:0] IN2_BUS,
  output logic [N-1:0]   GNT,
  output logic [W:0]     OUT,
  output logic [IDW-1:0] OUT_ID,
  output logic           OUT_VLD,
  output logic           BUSY,
  output logic [15:0]    CNT
);

  logic [W-1:0]   w_in1 [N];
  logic [W-1:0]   w_in2 [N];

  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] w_ptr_next;
  logic [IDW:0]   w_pos;
  logic [N-1:0]   w_gnt;
  logic           w_gnt_vld;
  logic [IDW-1:0] w_gnt_id;

  logic           r_s1_vld, r_s2_vld, r_out_vld;
  logic [W-1:0]   r_s1_a, r_s1_b, r_s2_a, r_s2_b;
  logic [IDW-1:0] r_s1_id, r_s2_id, r_out_id;
  logic [W:0]     r_out;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign w_in1[gi] = IN1_BUS[gi*W +: W];
      assign w_in2[gi] = IN2_BUS[gi*W +: W];
    end
  endgenerate

  // Search from r_ptr upward (mod N); the first active request wins.
  always_comb begin
    w_gnt     = '0;
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_pos     = '0;
    if (RST_N && EN) begin
      for (int k = 0; k < N; k++) begin
        w_pos = {1'b0, r_ptr} + (IDW+1)'(k);
        if (w_pos >= (IDW+1)'(N)) begin
          w_pos = w_pos - (IDW+1)'(N);
        end
        if (!w_gnt_vld && REQ[w_pos[IDW-1:0]]) begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = w_pos[IDW-1:0];
        end
      end
    end
    if (w_gnt_vld) begin
      w_gnt[w_gnt_id] = 1'b1;
    end
  end

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_gnt_vld) begin
      w_ptr_next = (w_gnt_id == IDW'(N-1)) ? '0 : w_gnt_id + IDW'(1);
    end
  end

  assign GNT = w_gnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ptr     <= '0;
      r_s1_vld  <= 1'b0;
      r_s1_a    <= '0;
      r_s1_b    <= '0;
      r_s1_id   <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_a    <= '0;
      r_s2_b    <= '0;
      r_s2_id   <= '0;
      r_out_vld <= 1'b0;
      r_out     <= '0;
      r_out_id  <= '0;
    end else begin
      r_ptr    <= w_ptr_next;
      r_s1_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_s1_a  <= w_in1[w_gnt_id];
        r_s1_b  <= w_in2[w_gnt_id];
        r_s1_id <= w_gnt_id;
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_a  <= r_s1_a;
        r_s2_b  <= r_s1_b;
        r_s2_id <= r_s1_id;
      end
      // Result registers hold their last value between valid pulses.
      r_out_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_out    <= {1'b0, r_s2_a} + {1'b0, r_s2_b};
        r_out_id <= r_s2_id;
      end
    end
  end

  assign OUT     = r_out;
  assign OUT_ID  = r_out_id;
  assign OUT_VLD = r_out_vld;
  assign BUSY    = r_s1_vld | r_s2_vld | r_out_vld;

`ifdef ADDER_ARB_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (r_out_vld && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign CNT = r_cnt;
`else
  assign CNT = '0;
`endif

endmodule

// File: tb/tb_adder_arb.sv
// Randomized and directed bench for adder_arb against a queue-based reference model.
module tb_adder_arb;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [N-1:0]   req;
  logic [N*W-1:0] in1_bus, in2_bus;
  logic [N-1:0]   gnt;
  logic [W:0]     out;
  logic [IDW-1:0] out_id;
  logic           out_vld;
  logic           busy;
  logic [15:0]    cnt;

  always #5 clk = ~clk;

  adder_arb #(.N(N), .W(W), .IDW(IDW)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .REQ(req),
    .IN1_BUS(in1_bus), .IN2_BUS(in2_bus), .GNT(gnt),
    .OUT(out), .OUT_ID(out_id), .OUT_VLD(out_vld), .BUSY(busy), .CNT(cnt)
  );

  typedef struct {
    int id;
    int sum;
    int due;
  } ent_t;

  ent_t m_q[$];
  int   m_ptr, m_last_out, m_last_id, m_cnt;
  int   cyc;
  int   g_id;
  int   a [N];
  int   b [N];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [N-1:0] snap_gnt;
  logic [15:0]  snap_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int exp_cnt();
`ifdef ADDER_ARB_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  // Entered just after a falling edge; leaves just after the next falling edge.
  task automatic run_cycle();
    bit   exp_vld;
    ent_t e;
    for (int i = 0; i < N; i++) begin
      in1_bus[i*W +: W] = a[i][W-1:0];
      in2_bus[i*W +: W] = b[i][W-1:0];
    end
    #1;
    exp_vld = (m_q.size() > 0) && (m_q[0].due == cyc);
    check_val("busy", 32'(busy), 32'(m_q.size() > 0));
    check_val("out_vld", 32'(out_vld), 32'(exp_vld));
    if (exp_vld) begin
      e = m_q.pop_front();
      m_last_out = e.sum;
      m_last_id  = e.id;
      $display("cyc=%0d result id=%0d sum=%0d (dut id=%0d sum=%0d)", cyc, e.id, e.sum, out_id, out);
    end
    check_val("out", 32'(out), m_last_out);
    check_val("out_id", 32'(out_id), m_last_id);
    check_val("cnt", 32'(cnt), exp_cnt());
    snap_cnt = cnt;
    if (exp_vld && m_cnt < 65535) m_cnt++;

    g_id = -1;
    if (rst_n && en) begin
      for (int k = 0; k < N; k++) begin
        if (g_id < 0 && req[(m_ptr + k) % N]) g_id = (m_ptr + k) % N;
      end
    end
    check_val("gnt", 32'(gnt), (g_id >= 0) ? (1 << g_id) : 0);
    snap_gnt = gnt;

    if (!rst_n) begin
      m_ptr = 0;
      m_q.delete();
      m_last_out = 0;
      m_last_id  = 0;
      m_cnt      = 0;
    end else if (g_id >= 0) begin
      m_q.push_back('{id: g_id, sum: a[g_id] + b[g_id], due: cyc + 3});
      m_ptr = (g_id + 1) % N;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    run_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; req = '0; in1_bus = '0; in2_bus = '0;
    for (int i = 0; i < N; i++) begin a[i] = 0; b[i] = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_ptr = 0; m_last_out = 0; m_last_id = 0; m_cnt = 0; cyc = 0;
    rst_n = 1'b1; en = 1'b1;

    // Single operation: 200+100 on requester 0
    a[0] = 200; b[0] = 100; req = 4'b0001;
    run_cycle();
    check_val("single_gnt", 32'(snap_gnt), 32'h1);
    idle(4);

    // Round-robin with all requesters held
    do_reset();
    for (int i = 0; i < N; i++) begin a[i] = i + 1; b[i] = i + 1; end
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      run_cycle();
      check_val("rr_gnt", 32'(snap_gnt), 32'(1 << (k % N)));
    end
    idle(4);

    // Priority rotation
    req = 4'b0100;
    run_cycle();
    check_val("rot_gnt2", 32'(snap_gnt), 32'h4);
    req = 4'b0011;
    run_cycle();
    check_val("rot_gnt0", 32'(snap_gnt), 32'h1);
    run_cycle();
    check_val("rot_gnt1", 32'(snap_gnt), 32'h2);
    idle(4);

    // Width boundaries
    a[0] = 255; b[0] = 255; req = 4'b0001;
    run_cycle();
    a[0] = 0; b[0] = 0;
    run_cycle();
    idle(4);

    // EN low blocks grants; reset discards in-flight ops
    en = 1'b0; req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      run_cycle();
      check_val("en0_gnt", 32'(snap_gnt), 32'h0);
    end
    en = 1'b1;
    run_cycle();
    run_cycle();
    do_reset();
    idle(4);
    req = 4'b1111;
    run_cycle();
    check_val("post_rst_gnt", 32'(snap_gnt), 32'h1);
    idle(4);

    // Counter: five back-to-back ops from one requester
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      a[0] = 10 + k; b[0] = k;
      run_cycle();
    end
    idle(4);
`ifdef ADDER_ARB_CNT_EN
    check_val("cnt5", 32'(snap_cnt), 32'd5);
`else
    check_val("cnt_off", 32'(snap_cnt), 32'd0);
`endif

    // Randomized traffic: requesters hold until granted, occasional drops, EN gaps and resets
    for (int t = 0; t < 400; t++) begin
      en    = ($urandom_range(0, 9) != 0);
      rst_n = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && g_id != i && $urandom_range(0, 9) != 0) begin
          req[i] = 1'b1;
        end else begin
          req[i] = 1'($urandom_range(0, 1));
          a[i] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
          b[i] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
        end
      end
      run_cycle();
    end
    rst_n = 1'b1; en = 1'b1;
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
